// File: rtl/mdu_iterative.sv
// Iterative MIPS32 multiply/divide unit owning the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, followed by a sign-fixup cycle.
module mdu_iterative #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    localparam int CW = $clog2(N + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic logic [N-1:0] absval(input logic [N-1:0] v, input logic sgn);
        return (sgn && v[N-1]) ? -v : v;
    endfunction

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // acc = {partial product, remaining multiplier bits}; the sum keeps its carry
    function automatic logic [2*N-1:0] mul_step(input logic [2*N-1:0] acc, input logic [N-1:0] mcand);
        logic [N:0] sum;
        sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : {(N+1){1'b0}});
        return {sum, acc[N-1:1]};
    endfunction

    // acc = {remainder, quotient}; the shifted remainder needs N+1 bits before the trial subtract
    function automatic logic [2*N-1:0] div_step(input logic [2*N-1:0] acc, input logic [N-1:0] dvsr);
        logic [N:0]     rem;
        logic [N:0]     trial;
        logic [2*N-1:0] res;
        rem   = acc[2*N-1:N-1];
        trial = rem - {1'b0, dvsr};
        if (!trial[N]) res = {trial[N-1:0], acc[N-2:0], 1'b1};
        else           res = {rem[N-1:0], acc[N-2:0], 1'b0};
        return res;
    endfunction

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic [N-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   opd_q, opd_d, rawa_q, rawa_d;
    logic           is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic           sgn_op;
    logic [N-1:0]   a_abs, b_abs;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix, rem_fix;

    assign sgn_op   = ~op[0];
    assign a_abs    = absval(inA, sgn_op);
    assign b_abs    = absval(inB, sgn_op);
    assign prod_fix = neg_2n(acc_q, neg_q);
    assign quo_fix  = neg_n(acc_q[N-1:0], neg_q);
    assign rem_fix  = neg_n(acc_q[2*N-1:N], rneg_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        rawa_d   = rawa_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d = op[1];
                            neg_d    = sgn_op & (inA[N-1] ^ inB[N-1]);
                            rneg_d   = sgn_op & inA[N-1];
                            dz_d     = op[1] && (inB == '0);
                            rawa_d   = inA;
                            opd_d    = op[1] ? b_abs : a_abs;
                            acc_d    = {{N{1'b0}}, (op[1] ? a_abs : b_abs)};
                            cnt_d    = CW'(N);
                            busy_d   = 1'b1;
                            state_d  = S_RUN;
                        end
                        3'b100:  hi_d = inA;
                        3'b101:  lo_d = inA;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_step(acc_q, opd_q) : mul_step(acc_q, opd_q);
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!flush) begin
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*N-1:N];
                        lo_d = prod_fix[N-1:0];
                    end else if (dz_q) begin
                        hi_d = rawa_q;
                        lo_d = {N{1'b1}};
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    done_d = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clock) begin
        acc_q    <= acc_d;
        opd_q    <= opd_d;
        rawa_q   <= rawa_d;
        is_div_q <= is_div_d;
        neg_q    <= neg_d;
        rneg_q   <= rneg_d;
        dz_q     <= dz_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed MIPS cases, boundary run, then random ops.
module tb_mdu_iterative;
    logic        clock, reset, start, flush;
    logic [2:0]  op;
    logic [31:0] inA, inB;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    logic [63:0] sb[$];

    mdu_iterative #(.N(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference result {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, q, r;
        logic [63:0] u;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        u   = '0;
        case (o)
            3'd0: begin q = sa * sbv; u = q; end
            3'd1: u = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) u = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    u = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 0) u = {a, 32'hFFFFFFFF};
                else u = {a % b, a / b};
            end
            default: u = '0;
        endcase
        return u;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                done_seen++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_done: got hi=%h lo=%h required no done", hi, lo);
                end else begin
                    e = sb.pop_front();
                    check("sb_hi", hi, e[63:32]);
                    check("sb_lo", lo, e[31:0]);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_res);
        @(posedge clock);
        #1;
        start = 1'b1; op = o; inA = a; inB = b;
        @(posedge clock);
        #1;
        start = 1'b0; op = 3'b111; inA = $urandom; inB = $urandom;
        if (expect_res) sb.push_back(model(o, a, b));
    endtask

    task automatic wait_done(input string name, output int bcyc);
        bit got;
        got  = 1'b0;
        bcyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin got = 1'b1; break; end
            if (busy === 1'b1) bcyc++;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s_timeout: got no done required done within 100 cycles", name);
        end
    endtask

    initial begin
        int bc, ds;
        logic [31:0] a, b;
        logic [2:0]  o;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; inA = '0; inB = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        ds = done_seen;
        issue(3'd0, 32'hFFFFFFFD, 32'd5, 1'b1);
        wait_done("mult_neg", bc);
        check("mult_busy_cycles", bc, 32'd33);
        @(negedge clock);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("done_count", done_seen - ds, 32'd1);

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); wait_done("multu_max", bc);
        issue(3'd3, 32'd100, 32'd7, 1'b1);             wait_done("divu", bc);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);        wait_done("div_neg", bc);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1); wait_done("div_ovf", bc);
        issue(3'd3, 32'd9, 32'd0, 1'b1);               wait_done("divu_zero", bc);
        check("divz_busy_cycles", bc, 32'd33);

        // MTHI then MTLO back to back
        ds = done_seen;
        @(posedge clock); #1;
        start = 1'b1; op = 3'd4; inA = 32'h1234;
        @(posedge clock); #1;
        op = 3'd5; inA = 32'h5678;
        @(negedge clock);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        @(posedge clock); #1;
        start = 1'b0; op = 3'b111;
        @(negedge clock);
        check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi_kept", hi, 32'h1234);
        check("mt_busy", {31'b0, busy}, 32'd0);
        check("mt_no_done", done_seen - ds, 32'd0);

        // flush and start together in idle: nothing accepted
        @(posedge clock); #1;
        start = 1'b1; flush = 1'b1; op = 3'd4; inA = 32'hDEAD;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0; op = 3'b111;
        @(negedge clock);
        check("flush_start_hi", hi, 32'h1234);
        check("flush_start_busy", {31'b0, busy}, 32'd0);

        // start while busy is ignored
        issue(3'd0, 32'd2, 32'd3, 1'b1);
        repeat (3) @(posedge clock);
        #1 start = 1'b1; op = 3'd3; inA = 32'd8; inB = 32'd2;
        @(posedge clock);
        #1 start = 1'b0; op = 3'b111;
        wait_done("mult_small", bc);
        repeat (40) @(negedge clock);
        check("ignored_hi", hi, 32'd0);
        check("ignored_lo", lo, 32'd6);
        check("ignored_busy", {31'b0, busy}, 32'd0);

        // flush mid-operation
        ds = done_seen;
        issue(3'd0, 32'd7, 32'd9, 1'b0);
        repeat (8) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flush_busy", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clock);
        check("flush_no_done", done_seen - ds, 32'd0);
        check("flush_hi", hi, 32'd0);
        check("flush_lo", lo, 32'd6);

        // reset mid-operation
        issue(3'd0, 32'd5, 32'd5, 1'b0);
        repeat (18) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 300) - 150; b = $urandom_range(0, 30) - 15; end
                2: begin a = $urandom; b = 32'd0; end
                default: begin
                    a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
                    b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h00000001;
                end
            endcase
            issue(o, a, b, 1'b1);
            wait_done("rand", bc);
            check("rand_busy_cycles", bc, 32'd33);
        end

        repeat (5) @(negedge clock);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Consumes the two register-file read operands (rdA, rdB) and implements MIPS32 MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers, which the writeback mux reads for MFHI/MFLO.
- Uses a 32-iteration shift-add multiplier and a restoring divider; the pipeline control stalls on busy.

Parameters:
N, 32, operand/HI/LO width; iteration count equals N.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on posedge while idle.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- inA  input  N  rs operand (multiplicand/dividend; MTHI/MTLO source).
- inB  input  N  rt operand (multiplier/divisor).
- flush  input  1  abort the in-flight operation.
- busy  output  1  high while an iterative op is in flight.
- done  output  1  one-cycle pulse when HI/LO receive a mult/div result.
- hi  output  N  HI register.
- lo  output  N  LO register.

Behaviour:
- Reset: on a posedge with reset=1, state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset overrides start and flush, including in the middle of an operation.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op in {000..011} (edge E0):
  - latch |inA| and |inB| for signed ops, raw values for unsigned ops;
  - latch the result sign flags;
  - set counter=N, busy=1, and go to RUN.
- IDLE, start=1, op=100: hi<=inA at the same edge; no busy, no done.
- IDLE, start=1, op=101: lo<=inA at the same edge; no busy, no done.
- IDLE, start=1, op=110/111: ignored.
- RUN: one iteration per edge (E1..EN); counter decrements; at counter==1 go to FIX.
  - Multiply: 2N-bit accumulator, add multiplicand if the multiplier LSB is 1, then shift right.
  - Divide: shift remainder:quotient left 1; trial-subtract the divisor; keep the result and set quotient bit if it is non-negative.
- FIX (edge EN+1):
  - apply the sign correction and write hi/lo;
  - done<=1 for exactly one cycle, busy<=0, return to IDLE.
  - Total latency: done is high in the cycle after edge E33 (N=32), i.e. 33 edges after acceptance.
- Sign rules (all arithmetic mod 2^N):
  - MULT: negate the 2N-bit product if the operand signs differ.
  - DIV: quotient negative if the signs differ; remainder takes the dividend's sign.
- Divide by zero (detected at E0, full latency kept):
  - lo=all-ones;
  - hi=inA as latched raw, i.e. unsigned dividend, or the signed dividend unchanged for DIV.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- start while busy: ignored and not queued; the caller holds start until busy=0.
- flush=1 while busy: return to IDLE at that edge; busy=0, no done, hi/lo unchanged.
- flush in IDLE: no effect.
- flush and start in the same IDLE cycle: flush wins; nothing is accepted.
- hi/lo are stable (previous values) throughout RUN; they change only at FIX, MTHI/MTLO, or reset.
- Operand inputs are don't-care after E0; they are internally latched.

Test Plan:
- Reset, then MULT inA=0xFFFFFFFD (-3), inB=5 -> busy for 33 cycles, single done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 -> lo=14, hi=2.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 9/0 -> lo=0xFFFFFFFF, hi=9, after the normal 33-cycle latency.
- MTHI 0x1234 and MTLO 0x5678 in consecutive idle cycles -> hi=0x1234 and lo=0x5678 the next cycle, busy and done never asserted.
- Boundary run:
  - MULT 2×3 with a second start DIVU 8/2 at cycle 5 -> ignored; only the MULT result lands (hi=0, lo=6).
  - A new MULT flushed at cycle 10 -> busy=0, no done, hi/lo still 0/6.
  - Another MULT with reset at cycle 20 -> hi=lo=0, busy=0, done=0 next cycle.
